segway_sequencer: RTL and testbench

Rider-detect and drive-enable sequencer for the Segway balance datapath. It qualifies the left/right load-cell weights, decides when steering may be enabled, and generates the 8-bit soft-start ramp that scales PID torque after power-up. Its outputs `ss_tmr`, `en_steer` and `rider_off` feed the torque-math block and the top-level control.

---
 rtl/segway_sequencer.sv | 162 ++++++++++++++++
 tb/tb_segway_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/segway_sequencer.sv
// rtl/segway_sequencer.sv - rider-detect, steer-enable sequencer and soft-start ramp
//
// Purpose: qualifies the registered left/right load-cell weights, walks an
// IDLE -> WAIT -> STEER_EN sequence with a settle timer and hysteresis, and
// produces an 8-bit saturating soft-start scale for the torque path.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pwr_up     drive authorised; low forces idle state and zero soft-start
//   ld_vld     one-cycle strobe, lft_ld/rght_ld valid
//   lft_ld     left load cell, 12-bit unsigned
//   rght_ld    right load cell, 12-bit unsigned
//   ss_tmr     soft-start scale 0..0xFF, saturating
//   en_steer   steering enabled (state STEER_EN)
//   rider_off  no rider detected (state IDLE)
`timescale 1ns/1ps

module segway_sequencer #(
    parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
    parameter logic [11:0] WT_HYSTERESIS = 12'h040,
    parameter logic        FAST_SIM      = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwr_up,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic [7:0]  ss_tmr,
    output logic        en_steer,
    output logic        rider_off
);

    // Thresholds in 13 bits; the low threshold clamps at zero instead of wrapping.
    localparam logic [12:0] THR_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYSTERESIS};
    localparam logic [12:0] THR_LO = (MIN_RIDER_WT >= WT_HYSTERESIS) ?
                                     ({1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS}) : 13'd0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [25:0]  r_tmr;
    logic [25:0]  w_tmr_nxt;
    logic [11:0]  r_lft_q;
    logic [11:0]  r_rght_q;
    logic [8:0]   r_pre;
    logic [7:0]   r_ss_tmr;

    logic [12:0]  w_sum;
    logic [11:0]  w_diff;
    logic [12:0]  w_sum_15_16;
    logic         w_sum_gt_min;
    logic         w_sum_lt_min;
    logic         w_diff_lt_qtr;
    logic         w_diff_gt_15_16;
    logic         w_tmr_full;

    // Load capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_q  <= 12'd0;
            r_rght_q <= 12'd0;
        end else if (ld_vld) begin
            r_lft_q  <= lft_ld;
            r_rght_q <= rght_ld;
        end
    end

    assign w_sum           = {1'b0, r_lft_q} + {1'b0, r_rght_q};
    assign w_diff          = (r_lft_q >= r_rght_q) ? (r_lft_q - r_rght_q) : (r_rght_q - r_lft_q);
    // sum >= sum>>4 always, so this cannot underflow.
    assign w_sum_15_16     = w_sum - (w_sum >> 4);
    assign w_sum_gt_min    = (w_sum > THR_HI);
    assign w_sum_lt_min    = (w_sum < THR_LO);
    assign w_diff_lt_qtr   = ({1'b0, w_diff} < (w_sum >> 2));
    assign w_diff_gt_15_16 = ({1'b0, w_diff} > w_sum_15_16);
    assign w_tmr_full      = FAST_SIM ? (&r_tmr[14:0]) : (&r_tmr);

    // FSM state and settle timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tmr   <= 26'd0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    // Next-state logic; sum inside the hysteresis band never changes state.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        case (r_state)
            IDLE: begin
                if (w_sum_gt_min) begin
                    w_state_nxt = WAIT;
                    w_tmr_nxt   = 26'd0;
                end
            end
            WAIT: begin
                if (w_sum_lt_min) begin
                    w_state_nxt = IDLE;
                    w_tmr_nxt   = 26'd0;
                end else if (!w_diff_lt_qtr) begin
                    // Imbalance restarts the whole settle period.
                    w_tmr_nxt   = 26'd0;
                end else if (w_tmr_full) begin
                    w_state_nxt = STEER_EN;
                end else begin
                    w_tmr_nxt   = r_tmr + 26'd1;
                end
            end
            STEER_EN: begin
                // Step-off to IDLE takes priority over the imbalance fallback.
                if (w_sum_lt_min) begin
                    w_state_nxt = IDLE;
                    w_tmr_nxt   = 26'd0;
                end else if (w_diff_gt_15_16) begin
                    w_state_nxt = WAIT;
                    w_tmr_nxt   = 26'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tmr_nxt   = 26'd0;
            end
        endcase
        if (!pwr_up) begin
            w_state_nxt = IDLE;
            w_tmr_nxt   = 26'd0;
        end
    end

    // Soft-start: ss_tmr steps when the prescaler wraps (or every clock in fast sim).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre    <= 9'd0;
            r_ss_tmr <= 8'd0;
        end else if (!pwr_up) begin
            r_pre    <= 9'd0;
            r_ss_tmr <= 8'd0;
        end else begin
            r_pre <= r_pre + 9'd1;
            if ((FAST_SIM || (r_pre == 9'h1FF)) && (r_ss_tmr != 8'hFF)) begin
                r_ss_tmr <= r_ss_tmr + 8'd1;
            end
        end
    end

    // Decoded straight from registers so an async reset shows up without a clock.
    assign ss_tmr    = r_ss_tmr;
    assign en_steer  = (r_state == STEER_EN);
    assign rider_off = (r_state == IDLE);

endmodule

// File: tb/tb_segway_sequencer.sv
// tb/tb_segway_sequencer.sv - directed self-checking bench for segway_sequencer (fast-sim timing)
`timescale 1ns/1ps

module tb_segway_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwr_up;
    logic        ld_vld;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [7:0]  ss_tmr;
    logic        en_steer;
    logic        rider_off;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;

    segway_sequencer #(
        .MIN_RIDER_WT  (12'h200),
        .WT_HYSTERESIS (12'h040),
        .FAST_SIM      (1'b1)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwr_up    (pwr_up),
        .ld_vld    (ld_vld),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .ss_tmr    (ss_tmr),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; ld_vld is high across exactly one rising edge.
    task automatic load(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
        ld_vld  = 1'b1;
        @(negedge clk);
        ld_vld  = 1'b0;
    endtask

    task automatic wait_steer(output int n);
        n = 0;
        while (!en_steer && n < 40000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        pwr_up  = 1'b1;
        ld_vld  = 1'b0;
        lft_ld  = 12'd0;
        rght_ld = 12'd0;
        tick(3);
        check_eq("rst_ss_tmr",    ss_tmr,    0);
        check_eq("rst_en_steer",  en_steer,  0);
        check_eq("rst_rider_off", rider_off, 1);

        // Soft-start ramp: one step per clock in fast sim, saturating at 0xFF.
        rst_n = 1'b1;
        check_eq("ss_start", ss_tmr, 0);
        for (int i = 1; i <= 255; i++) begin
            tick(1);
            check_eq("ss_ramp", ss_tmr, i);
        end
        tick(5);
        check_eq("ss_sat", ss_tmr, 8'hFF);
        pwr_up = 1'b0;
        tick(1);
        check_eq("ss_clear", ss_tmr, 0);
        pwr_up = 1'b1;

        // Hysteresis from IDLE: 0x230 and 0x240 are not above 0x240.
        load(12'h118, 12'h118);
        tick(3);
        check_eq("idle_hold_230", rider_off, 1);
        load(12'h120, 12'h120);
        tick(3);
        check_eq("idle_hold_240", rider_off, 1);

        // Mount: FSM acts one edge after the capture edge.
        load(12'h150, 12'h150);
        check_eq("mount_lat", rider_off, 1);
        tick(1);
        check_eq("mount_roff", rider_off, 0);
        check_eq("mount_en",   en_steer,  0);
        tick(200);
        check_eq("wait_no_steer", en_steer, 0);

        // Imbalance in WAIT clears the timer; rebalance waits a full 2^15.
        load(12'h300, 12'h080);
        tick(200);
        check_eq("imbal_en",   en_steer,  0);
        check_eq("imbal_wait", rider_off, 0);
        load(12'h150, 12'h150);
        wait_steer(cnt);
        check_eq("settle_cnt",  cnt,       32768);
        check_eq("settle_roff", rider_off, 0);

        // Hysteresis from STEER_EN: 0x1D0 and 0x1C0 are not below 0x1C0.
        load(12'h0E8, 12'h0E8);
        tick(3);
        check_eq("steer_hold_1d0", en_steer, 1);
        load(12'h0E0, 12'h0E0);
        tick(3);
        check_eq("steer_hold_1c0", en_steer, 1);

        // Step-off imbalance: diff 0x3E0 > 0x3C0 -> WAIT.
        load(12'h3F0, 12'h010);
        check_eq("stepoff_lat", en_steer, 1);
        tick(1);
        check_eq("stepoff_en",   en_steer,  0);
        check_eq("stepoff_wait", rider_off, 0);
        load(12'h150, 12'h150);
        wait_steer(cnt);
        check_eq("resettle_cnt", cnt, 32768);

        // sum 0x1B0 below threshold and diff above 15/16 together: IDLE wins.
        load(12'h1B0, 12'h000);
        tick(1);
        check_eq("both_idle_roff", rider_off, 1);
        check_eq("both_idle_en",   en_steer,  0);

        // pwr_up drop mid-WAIT.
        load(12'h150, 12'h150);
        tick(50);
        check_eq("wait2_roff", rider_off, 0);
        pwr_up = 1'b0;
        tick(1);
        check_eq("pwr_drop_roff", rider_off, 1);
        check_eq("pwr_drop_ss",   ss_tmr,    0);
        pwr_up = 1'b1;
        tick(2);
        check_eq("rewait_roff", rider_off, 0);
        check_eq("rewait_ss",   ss_tmr,    2);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_roff", rider_off, 1);
        check_eq("async_en",   en_steer,  0);
        check_eq("async_ss",   ss_tmr,    0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        check_eq("post_rst_idle", rider_off, 1);
        check_eq("post_rst_ss",   ss_tmr,    5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
